// File: rtl/corelet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : corelet_pkg
// Purpose  : Shared definitions for the corelet instruction sequencer:
//            inst word bit positions, sequencer state encoding and the
//            idle instruction word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package corelet_pkg;

  localparam int INST_W = 35;
  localparam int A_W    = 11;   // width of the packed SRAM address fields

  localparam int B_MODE     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both SRAMs deselected and not writing (active-low), everything else 0.
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1800C0000;

  typedef enum logic [3:0] {
    IDLE,
    W_FETCH,
    W_LOAD,
    W_GAP,
    A_FETCH,
    EXEC,
    WAIT_OF,
    ACC,
    DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/corelet_ctrl_beat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : beat_ctr
// Purpose  : Loadable down-counter used as the per-state beat counter.
//            Loading N-1 gives N beats; last is high on the final beat.
//            The count parks at zero once it gets there.
// Ports    : clk, reset (async, active-high)
//            load      - load load_val this cycle
//            load_val  - beats-1 for the state being entered
//            count     - remaining beats after the current one
//            last      - current beat is the final one
// Revision : 1.0 - initial release
// ============================================================================
module beat_ctr #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign last  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/corelet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : corelet_ctrl
// Purpose  : Sequences one convolution tile per kernel position: weight
//            fetch into L0, kernel load, activation fetch, execute, then
//            OFIFO drain with SFP accumulate into pmem.
// Ports    : clk, reset (async, active-high)
//            start        - one-cycle pulse, accepted only when idle
//            mode_os      - output-stationary select (skips kernel load)
//            num_act      - activations per kij
//            num_kij      - kernel positions per run
//            w_base/a_base/p_base - SRAM base addresses
//            ofifo_valid  - OFIFO holds a complete row
//            inst         - registered 35-bit corelet instruction word
//            busy         - run in progress
//            done         - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_os,
  input  logic [len_bw-1:0]  num_act,
  input  logic [3:0]         num_kij,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done
);

  // Wide enough for num_act as well as row+col-1 (the gap length).
  localparam int CW = ((len_bw > $clog2(row + col)) ? len_bw : $clog2(row + col)) + 1;
  localparam logic [CW-1:0] ONE = 1;

  state_t             r_state, w_state_next;
  logic               r_mode;
  logic [len_bw-1:0]  r_num_act;
  logic [3:0]         r_num_kij, r_k, w_k_next;
  logic [addr_bw-1:0] r_w_base, r_a_base, r_p_base;
  logic [addr_bw-1:0] w_kofs, w_xaddr, w_paddr;
  logic [CW-1:0]      w_span, w_idx, w_load_val, w_count;
  logic               w_load, w_last;
  logic [INST_W-1:0]  w_inst, r_inst;
  logic               r_busy, r_done;

  beat_ctr #(.WIDTH(CW)) u_beat (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .count    (w_count),
    .last     (w_last)
  );

  // Beats-1 of the current state; subtracting the remaining count gives
  // the up-going beat index t used for addressing.
  always_comb begin
    w_span = '0;
    case (r_state)
      W_FETCH:  w_span = CW'(row);
      W_LOAD:   w_span = CW'(col - 1);
      W_GAP:    w_span = CW'(row + col - 1);
      A_FETCH:  w_span = CW'(r_num_act);
      EXEC,
      ACC:      w_span = CW'(r_num_act) - ONE;
      default:  w_span = '0;
    endcase
  end

  assign w_idx  = w_span - w_count;
  assign w_kofs = addr_bw'(32'(r_k) * 32'(row));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the control word for the current state; the word is
  // registered, so it reaches the pins one cycle behind the state.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_inst       = INST_IDLE;
    w_xaddr      = '0;
    w_paddr      = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_k_next = '0;
          if (num_act == '0 || num_kij == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next = W_FETCH;
            w_load       = 1'b1;
            w_load_val   = CW'(row);
          end
        end
      end
      W_FETCH, A_FETCH: begin
        // row/num_act reads, then one extra beat for the L0 write of the
        // last word since the SRAM returns data a cycle after the read.
        w_inst[B_MODE]  = r_mode;
        w_inst[B_L0_WR] = (w_idx != '0);
        if (!w_last) begin
          w_inst[B_CEN_X] = 1'b0;
          w_xaddr = (r_state == W_FETCH) ? (r_w_base + w_kofs + addr_bw'(w_idx))
                                         : (r_a_base + addr_bw'(w_idx));
        end
        if (w_last) begin
          w_load = 1'b1;
          if (r_state == A_FETCH) begin
            w_state_next = EXEC;
            w_load_val   = CW'(r_num_act) - ONE;
          end else if (r_mode) begin
            w_state_next = A_FETCH;
            w_load_val   = CW'(r_num_act);
          end else begin
            w_state_next = W_LOAD;
            w_load_val   = CW'(col - 1);
          end
        end
      end
      W_LOAD: begin
        w_inst[B_MODE]  = r_mode;
        w_inst[B_L0_RD] = 1'b1;
        w_inst[B_LOAD]  = 1'b1;
        if (w_last) begin
          w_state_next = W_GAP;
          w_load       = 1'b1;
          w_load_val   = CW'(row + col - 1);
        end
      end
      W_GAP: begin
        w_inst[B_MODE] = r_mode;
        if (w_last) begin
          w_state_next = A_FETCH;
          w_load       = 1'b1;
          w_load_val   = CW'(r_num_act);
        end
      end
      EXEC: begin
        w_inst[B_MODE]  = r_mode;
        w_inst[B_L0_RD] = 1'b1;
        w_inst[B_EXEC]  = 1'b1;
        if (w_last) begin
          w_state_next = WAIT_OF;
        end
      end
      WAIT_OF: begin
        w_inst[B_MODE] = r_mode;
        if (ofifo_valid) begin
          w_state_next = ACC;
          w_load       = 1'b1;
          w_load_val   = CW'(r_num_act) - ONE;
        end
      end
      ACC: begin
        w_inst[B_MODE]     = r_mode;
        w_inst[B_ACC]      = 1'b1;
        w_inst[B_OFIFO_RD] = 1'b1;
        w_inst[B_CEN_P]    = 1'b0;
        w_inst[B_WEN_P]    = 1'b0;
        w_paddr            = r_p_base + addr_bw'(w_idx);
        if (w_last) begin
          if (r_k < r_num_kij - 4'd1) begin
            w_k_next     = r_k + 4'd1;
            w_state_next = W_FETCH;
            w_load       = 1'b1;
            w_load_val   = CW'(row);
          end else begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    w_inst[B_AX_LSB +: A_W] = A_W'(w_xaddr);
    w_inst[B_AP_LSB +: A_W] = A_W'(w_paddr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k       <= '0;
      r_mode    <= 1'b0;
      r_num_act <= '0;
      r_num_kij <= '0;
      r_w_base  <= '0;
      r_a_base  <= '0;
      r_p_base  <= '0;
      r_inst    <= INST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_k    <= w_k_next;
      r_inst <= w_inst;
      r_busy <= (w_state_next != IDLE);
      r_done <= (r_state == DONE);
      if (r_state == IDLE && start) begin
        r_mode    <= mode_os;
        r_num_act <= num_act;
        r_num_kij <= num_kij;
        r_w_base  <= w_base;
        r_a_base  <= a_base;
        r_p_base  <= p_base;
      end
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_corelet_ctrl
// Purpose  : Self-checking bench for corelet_ctrl. Each run builds the full
//            expected cycle-by-cycle trace of inst/busy/done from the
//            sequencing rules, then drives start/ofifo_valid and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_corelet_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode_os = 1'b0;
  logic [10:0] num_act = '0;
  logic [3:0]  num_kij = '0;
  logic [10:0] w_base = '0;
  logic [10:0] a_base = '0;
  logic [10:0] p_base = '0;
  logic        ofifo_valid = 1'b0;
  logic [34:0] inst;
  logic        busy;
  logic        done;

  corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(11), .len_bw(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_os     (mode_os),
    .num_act     (num_act),
    .num_kij     (num_kij),
    .w_base      (w_base),
    .a_base      (a_base),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected trace, one entry per cycle starting the cycle after start.
  logic [34:0] q_inst[$];
  logic        q_busy[$];
  logic        q_done[$];
  logic        q_ofv[$];
  int          dup_idx;
  int          acc_idx;

  task automatic check_val(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Field-level word builder; WEN_xmem is always 1 and the ififo bits 0.
  function automatic logic [34:0] mk(input bit m, input bit acc, input bit cenp, input bit wenp,
                                     input logic [10:0] ap, input bit cenx, input logic [10:0] ax,
                                     input bit ofrd, input bit l0rd, input bit l0wr,
                                     input bit ex, input bit ld);
    return {m, acc, cenp, wenp, ap, cenx, 1'b1, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
  endfunction

  function automatic logic [34:0] idle_w(input bit m);
    return mk(m, 0, 1, 1, 11'd0, 1, 11'd0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input logic [34:0] w, input logic b, input logic d);
    q_inst.push_back(w);
    q_busy.push_back(b);
    q_done.push_back(d);
    q_ofv.push_back($urandom_range(0, 3) == 0);   // stray valid outside WAIT is ignored
  endtask

  task automatic build(input bit m, input int t_act, input int nk, input logic [10:0] wb,
                       input logic [10:0] ab, input logic [10:0] pb, input int wfix);
    int le;
    int wc;
    logic [10:0] ad;
    q_inst.delete(); q_busy.delete(); q_done.delete(); q_ofv.delete();
    dup_idx = -1;
    acc_idx = -1;
    push(idle_w(0), 1, 0);
    if (t_act > 0 && nk > 0) begin
      for (int k = 0; k < nk; k++) begin
        for (int t = 0; t <= ROW; t++) begin
          ad = wb + 11'(k * ROW + t);
          if (t < ROW) push(mk(m, 0, 1, 1, 0, 0, ad, 0, 0, t > 0, 0, 0), 1, 0);
          else         push(mk(m, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0), 1, 0);
        end
        if (!m) begin
          for (int t = 0; t < COL; t++) push(mk(m, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1), 1, 0);
          for (int t = 0; t < ROW + COL; t++) push(idle_w(m), 1, 0);
        end
        for (int t = 0; t <= t_act; t++) begin
          ad = ab + 11'(t);
          if (t < t_act) push(mk(m, 0, 1, 1, 0, 0, ad, 0, 0, t > 0, 0, 0), 1, 0);
          else           push(mk(m, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0), 1, 0);
        end
        for (int t = 0; t < t_act; t++) begin
          if (k == 0 && t == 0) dup_idx = q_inst.size();
          push(mk(m, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0), 1, 0);
        end
        // WAIT lasts wc cycles: valid low for its first wc-1 cycles, high on the last.
        le = q_inst.size() - 1;
        wc = (wfix > 0) ? wfix : int'($urandom_range(1, 6));
        for (int i = 0; i < wc; i++) push(idle_w(m), 1, 0);
        for (int i = le; i < le + wc - 1; i++) q_ofv[i] = 1'b0;
        q_ofv[le + wc - 1] = 1'b1;
        for (int t = 0; t < t_act; t++) begin
          if (k == 0 && t == 0) acc_idx = q_inst.size();
          ad = pb + 11'(t);
          push(mk(m, 1, 0, 0, ad, 1, 0, 1, 0, 0, 0, 0), 1, 0);
        end
      end
    end
    push(idle_w(0), 0, 1);
    push(idle_w(0), 0, 0);
  endtask

  task automatic run(input bit m, input int t_act, input int nk, input logic [10:0] wb,
                     input logic [10:0] ab, input logic [10:0] pb, input int wfix,
                     input bit dup, input bit abort);
    build(m, t_act, nk, wb, ab, pb, wfix);
    @(negedge clk);
    start   = 1'b1;
    mode_os = m;
    num_act = 11'(t_act);
    num_kij = 4'(nk);
    w_base  = wb;
    a_base  = ab;
    p_base  = pb;
    for (int j = 0; j < q_inst.size(); j++) begin
      @(negedge clk);
      if (j == 0) begin
        // Inputs after the accepted start must not matter.
        mode_os = ~m;
        num_act = 11'($urandom);
        num_kij = 4'($urandom);
        w_base  = 11'($urandom);
        a_base  = 11'($urandom);
        p_base  = 11'($urandom);
      end
      check_val($sformatf("inst[%0d]", j), inst, q_inst[j]);
      check_val($sformatf("busy[%0d]", j), {34'd0, busy}, {34'd0, q_busy[j]});
      check_val($sformatf("done[%0d]", j), {34'd0, done}, {34'd0, q_done[j]});
      ofifo_valid = q_ofv[j];
      start = dup && (j == dup_idx);
      if (abort && j == acc_idx + 1) begin
        reset = 1'b1;
        #1;
        check_val("abort_inst", inst, idle_w(0));
        check_val("abort_busy", {34'd0, busy}, 35'd0);
        check_val("abort_done", {34'd0, done}, 35'd0);
        @(negedge clk);
        reset = 1'b0;
        break;
      end
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_inst", inst, idle_w(0));
    check_val("rst_busy", {34'd0, busy}, 35'd0);
    check_val("rst_done", {34'd0, done}, 35'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_inst", inst, idle_w(0));
    check_val("idle_busy", {34'd0, busy}, 35'd0);

    run(0, 4, 1, 11'd0, 11'd16, 11'd0, 6, 0, 0);
    run(0, 4, 3, 11'd0, 11'd16, 11'd0, 0, 0, 0);
    run(1, 5, 2, 11'd100, 11'd200, 11'd300, 0, 0, 0);
    run(0, 0, 3, 11'd5, 11'd6, 11'd7, 0, 0, 0);
    run(1, 3, 0, 11'd5, 11'd6, 11'd7, 0, 0, 0);
    run(0, 6, 2, 11'd32, 11'd64, 11'd128, 0, 1, 0);
    run(0, 5, 2, 11'd40, 11'd80, 11'd120, 0, 0, 1);
    run(0, 3, 2, 11'd40, 11'd80, 11'd120, 0, 0, 0);
    run(0, 4, 2, 11'd2040, 11'd2046, 11'd2045, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      run(1'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(1, 4)),
          11'($urandom), 11'($urandom), 11'($urandom), 0, 1'($urandom), 0);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
